led_pattern_gen: RTL

Multi-channel, runtime-configurable LED driver. It is the parametrised successor of the single-LED fixed-rate blinker. Each of NUM_LED channels independently runs OFF, ON, BLINK (programmable half-period) or BREATHE (PWM triangle ramp). Channels are configured through a valid/ready write port from the board control logic. Sits between the system control FSM and the board LED pins, clocked on blink_clk.

---
 rtl/led_pattern_gen.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: NUM_LED independent LED channels, each OFF, ON, BLINK or
// BREATHE, reconfigured at runtime through a valid/ready write port. Every
// channel has its own period counter. The BREATHE channels share a single
// free-running PWM counter.
module led_pattern_gen #(
   parameter int          NUM_LED         = 4,
   parameter int          CNT_W           = 32,
   parameter int unsigned DEF_HALF_PERIOD = 50000000,
   parameter int          PWM_W           = 8,
   localparam int         CH_W            = (NUM_LED > 1) ? $clog2(NUM_LED) : 1
) (
   input  logic               blink_clk,
   input  logic               sys_rst_n,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [CH_W-1:0]    cfg_ch,
   input  logic [1:0]         cfg_mode,
   input  logic [CNT_W-1:0]   cfg_half_period,
   output logic               cfg_err,
   output logic [NUM_LED-1:0] led_out
);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_e;

   localparam logic [PWM_W-1:0] DUTY_MAX = '1;

   mode_e              mode_q [NUM_LED];
   mode_e              mode_d [NUM_LED];
   logic [CNT_W-1:0]   half_q [NUM_LED];
   logic [CNT_W-1:0]   half_d [NUM_LED];
   logic [CNT_W-1:0]   cnt_q  [NUM_LED];
   logic [CNT_W-1:0]   cnt_d  [NUM_LED];
   logic [PWM_W-1:0]   duty_q [NUM_LED];
   logic [PWM_W-1:0]   duty_d [NUM_LED];
   logic [NUM_LED-1:0] tog_q, tog_d;
   logic [NUM_LED-1:0] dir_q, dir_d;
   logic [NUM_LED-1:0] led_q, led_d;
   logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
   logic               cfg_ready_q, cfg_ready_d;
   logic               cfg_err_q, cfg_err_d;

   logic               accept;
   logic               ch_ok;
   logic [CNT_W-1:0]   half_load;

   assign accept    = cfg_valid && cfg_ready_q;
   assign ch_ok     = (32'(cfg_ch) < NUM_LED);
   // A zero half-period would stall the counter on its terminal value, so it is loaded as 1.
   assign half_load = (cfg_half_period == '0) ? CNT_W'(1) : cfg_half_period;

   // Handshake and shared PWM counter next state.
   always_comb begin
      pwm_cnt_d   = pwm_cnt_q + 1'b1;
      // Ready drops for exactly one cycle after each accept.
      cfg_ready_d = !accept;
      cfg_err_d   = accept && !ch_ok;
   end

   // Per-channel next state: a write to the channel overrides its terminal event.
   always_comb begin
      // NOTE: every target gets a default first, so no path can infer a latch.
      tog_d = tog_q;
      dir_d = dir_q;
      for (int i = 0; i < NUM_LED; i++) begin
         mode_d[i] = mode_q[i];
         half_d[i] = half_q[i];
         cnt_d[i]  = cnt_q[i];
         duty_d[i] = duty_q[i];
         if (accept && ch_ok && (cfg_ch == CH_W'(i))) begin
            mode_d[i] = mode_e'(cfg_mode);
            half_d[i] = half_load;
            cnt_d[i]  = '0;
            tog_d[i]  = 1'b0;
            duty_d[i] = '0;
            dir_d[i]  = 1'b0;
         end else if (cnt_q[i] == half_q[i]) begin
            cnt_d[i] = '0;
            case (mode_q[i])
               MODE_BLINK: tog_d[i] = ~tog_q[i];
               MODE_BREATHE: begin
                  if (!dir_q[i]) begin
                     duty_d[i] = duty_q[i] + 1'b1;
                     if (duty_q[i] == DUTY_MAX - 1'b1) dir_d[i] = 1'b1;
                  end else begin
                     duty_d[i] = duty_q[i] - 1'b1;
                     if (duty_q[i] == PWM_W'(1)) dir_d[i] = 1'b0;
                  end
               end
               default: ;
            endcase
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   // LED drive decode from the current channel state; it is registered below.
   always_comb begin
      led_d = '0;
      for (int i = 0; i < NUM_LED; i++) begin
         case (mode_q[i])
            MODE_OFF:     led_d[i] = 1'b0;
            MODE_ON:      led_d[i] = 1'b1;
            MODE_BLINK:   led_d[i] = tog_q[i];
            MODE_BREATHE: led_d[i] = (pwm_cnt_q < duty_q[i]);
            default:      led_d[i] = 1'b0;
         endcase
      end
   end

   // State registers. Every channel comes out of reset blinking at the default rate.
   always_ff @(posedge blink_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         // NOTE: the channel arrays are plain flops, not RAM, so they are reset element by element.
         for (int i = 0; i < NUM_LED; i++) begin
            mode_q[i] <= MODE_BLINK;
            half_q[i] <= CNT_W'(DEF_HALF_PERIOD);
            cnt_q[i]  <= '0;
            duty_q[i] <= '0;
         end
         tog_q       <= '0;
         dir_q       <= '0;
         led_q       <= '0;
         pwm_cnt_q   <= '0;
         cfg_ready_q <= 1'b1;
         cfg_err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so every register samples values from before the edge.
         for (int i = 0; i < NUM_LED; i++) begin
            mode_q[i] <= mode_d[i];
            half_q[i] <= half_d[i];
            cnt_q[i]  <= cnt_d[i];
            duty_q[i] <= duty_d[i];
         end
         tog_q       <= tog_d;
         dir_q       <= dir_d;
         led_q       <= led_d;
         pwm_cnt_q   <= pwm_cnt_d;
         cfg_ready_q <= cfg_ready_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign cfg_ready = cfg_ready_q;
   assign cfg_err   = cfg_err_q;
   assign led_out   = led_q;

endmodule
